edge_period_meter: RTL

- Downstream consumer of the 1-bit registered output `d` produced by the counter test stage.
- Detects rising and falling edges on `din`.
- Measures the period (cycles between successive rising edges) and the high time (cycles `din`=1 within that period), with saturating counters.
- Presents each measurement through a one-slot valid/ready output register and counts dropped measurements.

---
 rtl/edge_period_meter_pkg.sv | 23 ++
 rtl/edge_period_meter_edge_detect.sv | 32 +++
 rtl/edge_period_meter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/edge_period_meter_pkg.sv
// ------------------------------------------------------------------
// edge_period_meter_pkg : shared types and states for the period meter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package edge_period_meter_pkg;

  typedef logic        bool;
  typedef logic [7:0]  uint8_t;
  typedef logic [15:0] uint16_t;

  typedef enum logic [0:0] {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  localparam bool true  = 1'b1;
  localparam bool false = 1'b0;

endpackage

`default_nettype wire

// File: rtl/edge_period_meter_edge_detect.sv
// ------------------------------------------------------------------
// edge_detect : registers the previous input sample, flags rise / fall
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module edge_detect
  import edge_period_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output bool  rise,
  output bool  fall,
  output logic prev
);

  // The history register keeps tracking din even while measurement is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;
  assign fall = ~din & prev;

endmodule

`default_nettype wire

// File: rtl/edge_period_meter.sv
// ------------------------------------------------------------------
// edge_period_meter : saturating period / high-time meter, one-slot output
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module edge_period_meter
  import edge_period_meter_pkg::*;
#(
  parameter int W   = 16,
  parameter int OVW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_period,
  output logic [W-1:0]   out_high,
  output logic           out_sat,
  output logic [OVW-1:0] overrun
);

  localparam logic [W-1:0]   MAXC    = {W{1'b1}};
  localparam logic [W-1:0]   CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [OVW-1:0] OV_MAX  = {OVW{1'b1}};
  localparam logic [OVW-1:0] OV_ONE  = {{(OVW-1){1'b0}}, 1'b1};

  bool          rise;
  bool          fall;
  logic         prev_din;
  logic         unused_edge;

  meter_state_t state, state_d;
  logic [W-1:0] cnt, cnt_d;
  logic [W-1:0] hcnt, hcnt_d;
  logic         sat, sat_d;
  bool          capture;
  logic         slot_free;

  edge_detect u_edge_detect (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .rise (rise),
    .fall (fall),
    .prev (prev_din)
  );

  assign unused_edge = fall ^ prev_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEEK;
      cnt   <= '0;
      hcnt  <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      hcnt  <= hcnt_d;
      sat   <= sat_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hcnt_d  = hcnt;
    sat_d   = sat;
    capture = false;
    if (!en) begin
      state_d = SEEK;
      cnt_d   = '0;
      hcnt_d  = '0;
      sat_d   = 1'b0;
    end else begin
      case (state)
        SEEK: begin
          // First rise only establishes the reference point.
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            sat_d   = 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            capture = true;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            sat_d   = 1'b0;
          end else begin
            if (cnt == MAXC) begin
              sat_d = 1'b1;
            end else begin
              cnt_d = cnt + CNT_ONE;
            end
            if (din) begin
              if (hcnt == MAXC) begin
                sat_d = 1'b1;
              end else begin
                hcnt_d = hcnt + CNT_ONE;
              end
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  assign slot_free = ~out_valid | out_ready;

  // A capture into a draining slot replaces the data without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_period <= '0;
      out_high   <= '0;
      out_sat    <= 1'b0;
      overrun    <= '0;
    end else if (capture) begin
      if (slot_free) begin
        out_valid  <= 1'b1;
        out_period <= cnt;
        out_high   <= hcnt;
        out_sat    <= sat;
      end else if (overrun != OV_MAX) begin
        overrun <= overrun + OV_ONE;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
